// File: rtl/rgb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// rgb_pkg : shared types for the RGB PWM stage and its duty source
// Rev 1.0
// ---------------------------------------------------------------
package rgb_pkg;

  localparam int DEFAULT_PWM_WIDTH = 8;

  typedef logic [DEFAULT_PWM_WIDTH-1:0] duty_t;

  typedef struct packed {
    duty_t r;
    duty_t g;
    duty_t b;
  } rgb_duty_t;

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_if.sv
`default_nettype none
// ---------------------------------------------------------------
// rgb_pwm_if : duty update port (valid/ready) of the RGB PWM stage
// Rev 1.0
// ---------------------------------------------------------------
interface rgb_pwm_if #(
  parameter int PWM_WIDTH = rgb_pkg::DEFAULT_PWM_WIDTH
);

  logic [PWM_WIDTH-1:0] duty_r;
  logic [PWM_WIDTH-1:0] duty_g;
  logic [PWM_WIDTH-1:0] duty_b;
  logic                 duty_valid;
  logic                 duty_ready;

  modport master (
    output duty_r, duty_g, duty_b, duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_r, duty_g, duty_b, duty_valid,
    output duty_ready
  );

endinterface
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ---------------------------------------------------------------
// pwm_channel : one PWM output with its active duty register
// Optional macro RGB_PWM_FADE_EN: step active toward a target once per period
// Rev 1.0
// ---------------------------------------------------------------
module pwm_channel #(
  parameter int PWM_WIDTH = rgb_pkg::DEFAULT_PWM_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PWM_WIDTH-1:0] cnt,
  input  logic                 boundary,
  input  logic                 load,
  input  logic [PWM_WIDTH-1:0] pending,
  output logic                 led
);

  logic [PWM_WIDTH-1:0] active;

`ifdef RGB_PWM_FADE_EN
  logic [PWM_WIDTH-1:0] target;

  // The step uses the target as it stood before this boundary's load.
  always_ff @(posedge clock) begin
    if (reset) begin
      active <= '0;
      target <= '0;
    end else if (boundary) begin
      if (active < target)
        active <= active + 1'b1;
      else if (active > target)
        active <= active - 1'b1;
      if (load)
        target <= pending;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset)
      active <= '0;
    else if (boundary && load)
      active <= pending;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset)
      led <= 1'b0;
    else
      led <= (cnt < active);
  end

endmodule
`default_nettype wire

// File: rtl/rgb_pwm.sv
`default_nettype none
// ---------------------------------------------------------------
// rgb_pwm : three-channel PWM, duties applied only at period boundaries
// Optional macro RGB_PWM_FADE_EN (linear fade, one duty step per period)
// Rev 1.0
// ---------------------------------------------------------------
module rgb_pwm
  import rgb_pkg::*;
#(
  parameter int PWM_WIDTH = DEFAULT_PWM_WIDTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  rgb_pwm_if.slave   bus,
  output logic       period_start,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);

  // Period is MAX ticks, so the counter wraps from MAX-1.
  localparam logic [PWM_WIDTH-1:0] CNT_LAST = {{(PWM_WIDTH-1){1'b1}}, 1'b0};

  logic [PWM_WIDTH-1:0] cnt;
  logic [PWM_WIDTH-1:0] pending [3];
  logic [PWM_WIDTH-1:0] duty_in [3];
  logic                 pending_valid;
  logic                 boundary;
  logic                 accept;
  logic [2:0]           led;

  assign boundary       = tick && (cnt == CNT_LAST);
  assign period_start   = boundary;
  assign bus.duty_ready = !pending_valid;
  assign accept         = bus.duty_valid && !pending_valid;

  assign duty_in[0] = bus.duty_r;
  assign duty_in[1] = bus.duty_g;
  assign duty_in[2] = bus.duty_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt           <= '0;
      pending_valid <= 1'b0;
      for (int i = 0; i < 3; i++)
        pending[i] <= '0;
    end else begin
      if (tick)
        cnt <= boundary ? '0 : cnt + 1'b1;
      // Apply and accept are exclusive: one needs pending full, the other empty.
      if (boundary && pending_valid) begin
        pending_valid <= 1'b0;
      end else if (accept) begin
        pending_valid <= 1'b1;
        for (int i = 0; i < 3; i++)
          pending[i] <= duty_in[i];
      end
    end
  end

  generate
    for (genvar i = 0; i < 3; i++) begin : g_channel
      pwm_channel #(
        .PWM_WIDTH (PWM_WIDTH)
      ) u_channel (
        .clock    (clock),
        .reset    (reset),
        .cnt      (cnt),
        .boundary (boundary),
        .load     (pending_valid),
        .pending  (pending[i]),
        .led      (led[i])
      );
    end
  endgenerate

  assign led_r = led[0];
  assign led_g = led[1];
  assign led_b = led[2];

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_rgb_pwm : randomized + directed scoreboard bench for rgb_pwm
// Rev 1.0
// ---------------------------------------------------------------
module tb_rgb_pwm;
  import rgb_pkg::*;

  localparam int MAX = 255;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
    logic ready;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b0;
  logic period_start, led_r, led_g, led_b;

  rgb_pwm_if #(.PWM_WIDTH(8)) bus ();

  rgb_pwm #(.PWM_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .bus          (bus),
    .period_start (period_start),
    .led_r        (led_r),
    .led_g        (led_g),
    .led_b        (led_b)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   prints = 0;
  bit   running = 1'b1;
  exp_t sb[$];

  // Reference model: position within the period and the three duties as integers.
  int m_phase = 0;
  int m_act[3];
  int m_tgt[3];
  int m_pend[3];
  bit m_pv = 1'b0;
  bit m_led[3];

  always @(posedge clock) begin
    bit bnd, acc;
    int din[3];
    din[0] = int'(bus.duty_r);
    din[1] = int'(bus.duty_g);
    din[2] = int'(bus.duty_b);
    if (reset) begin
      m_phase = 0;
      m_pv    = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_act[i] = 0; m_tgt[i] = 0; m_pend[i] = 0; m_led[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++)
        m_led[i] = (m_phase < m_act[i]);
      bnd = tick && (m_phase == MAX - 1);
      acc = bus.duty_valid && !m_pv;
      if (bnd) begin
        for (int i = 0; i < 3; i++) begin
`ifdef RGB_PWM_FADE_EN
          if (m_act[i] < m_tgt[i]) m_act[i] = m_act[i] + 1;
          else if (m_act[i] > m_tgt[i]) m_act[i] = m_act[i] - 1;
          if (m_pv) m_tgt[i] = m_pend[i];
`else
          if (m_pv) m_act[i] = m_pend[i];
`endif
        end
      end
      if (bnd && m_pv)
        m_pv = 1'b0;
      else if (acc) begin
        m_pv = 1'b1;
        for (int i = 0; i < 3; i++) m_pend[i] = din[i];
      end
      if (tick) m_phase = (m_phase + 1) % MAX;
    end
    sb.push_back('{r: m_led[0], g: m_led[1], b: m_led[2], ready: !m_pv});
  end

  // Monitor: one expected output set per clock, compared mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_ps;
    if (running) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        e = sb.pop_front();
        if ({led_r, led_g, led_b, bus.duty_ready} !== {e.r, e.g, e.b, e.ready}) begin
          errors++;
          if (prints < 40) begin
            prints++;
            $display("FAIL outputs at %0t: got rgb=%b%b%b ready=%b, expected rgb=%b%b%b ready=%b",
                     $time, led_r, led_g, led_b, bus.duty_ready, e.r, e.g, e.b, e.ready);
          end
        end
      end
      exp_ps = tick && (m_phase == MAX - 1);
      checks++;
      if (period_start !== exp_ps) begin
        errors++;
        if (prints < 40) begin
          prints++;
          $display("FAIL period_start at %0t: got %b, expected %b", $time, period_start, exp_ps);
        end
      end
    end
  end

  // 0: tick every clock, 1: every 4th clock, 2: random
  int tick_mode = 0;
  int tcount = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      case (tick_mode)
        0:       tick = 1'b1;
        1:       tick = ((tcount % 4) == 3);
        default: tick = ($urandom_range(0, 2) == 0);
      endcase
      tcount++;
    end
  endtask

  task automatic write_duty(input int r, input int g, input int b);
    bus.duty_r = 8'(r);
    bus.duty_g = 8'(g);
    bus.duty_b = 8'(b);
    bus.duty_valid = 1'b1;
    step(1);
    bus.duty_valid = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!bus.duty_ready && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    if (!bus.duty_ready) begin
      errors++;
      $display("FAIL wait_ready timeout: ready=%b after %0d cycles, expected 1", bus.duty_ready, n);
    end
  endtask

  task automatic wait_boundary_cycle(input int limit);
    int n = 0;
    while (!(tick && m_phase == MAX - 1) && n < limit) begin
      step(1);
      n++;
    end
    checks++;
    if (!(tick && m_phase == MAX - 1)) begin
      errors++;
      $display("FAIL wait_boundary timeout: phase=%0d, expected %0d", m_phase, MAX - 1);
    end
  endtask

  initial begin
    bus.duty_r = '0;
    bus.duty_g = '0;
    bus.duty_b = '0;
    bus.duty_valid = 1'b0;

    step(3);
    reset = 1'b0;
    tick_mode = 0;
    step(300);

    // Mid-period update, then three full periods.
    step(40);
    write_duty(64, 0, 255);
    step(3 * MAX);

    // Back-to-back: second write is ignored, rewrite lands one boundary later.
    bus.duty_r = 8'd20; bus.duty_g = 8'd30; bus.duty_b = 8'd40;
    bus.duty_valid = 1'b1;
    step(1);
    bus.duty_r = 8'd10;
    step(1);
    bus.duty_valid = 1'b0;
    wait_ready(2 * MAX);
    write_duty(10, 30, 40);
    step(2 * MAX + 20);

    // Accept on the exact boundary cycle.
    wait_ready(2 * MAX);
    wait_boundary_cycle(2 * MAX);
    write_duty(200, 100, 1);
    step(2 * MAX + 20);

    // Slow tick: every 4th clock.
    tick_mode = 1;
    wait_ready(3000);
    write_duty(3, 254, 128);
    step(3 * 4 * MAX);

    // Reset mid-period with an update pending.
    tick_mode = 0;
    write_duty(77, 88, 99);
    step(5);
    write_duty(5, 6, 7);
    step(30);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2 * MAX + 10);

    // Fade scenario (direct load when the fade macro is off).
    write_duty(5, 0, 0);
    step(8 * MAX);
    write_duty(2, 0, 0);
    step(5 * MAX);

    // Randomized traffic.
    tick_mode = 2;
    for (int k = 0; k < 40; k++) begin
      step($urandom_range(1, 150));
      if ($urandom_range(0, 1) == 1)
        write_duty($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
    end
    step(10);

    @(posedge clock);
    #2;
    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
